// File: rtl/rcb_alloc.sv
// rcb_alloc: crossbar allocator, per-output round-robin, connection held from grant until the owner's tail
//   clk, rst_n : clock, asynchronous active-low reset
//   req[i][j]  : input i requests output j (one-hot per input)
//   tail[i]    : input i finished its packet, release its connection
//   cfg[j][i]  : input i connected to output j (at most one bit per row)
//   gnt[i]     : input i owns some output
//   err[i]     : req[i] was multi-hot on the previous edge
module rcb_alloc #(
  parameter int NN = 5,
  parameter int MN = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NN-1:0][MN-1:0]  req,
  input  logic [NN-1:0]          tail,
  output logic [MN-1:0][NN-1:0]  cfg,
  output logic [NN-1:0]          gnt,
  output logic [NN-1:0]          err
);
  localparam int PW = NN > 1 ? $clog2(NN) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  logic [NN-1:0] multi;
  logic [NN-1:0] err_q;
  always_comb begin
    for (int i = 0; i < NN; i++) multi[i] = |(req[i] & (req[i] - MN'(1)));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else err_q <= multi;
  end
  assign err = err_q;
  always_comb begin
    gnt = '0;
    for (int j = 0; j < MN; j++) gnt = gnt | cfg[j];
  end
  for (genvar j = 0; j < MN; j++) begin : g_out
    state_t        state_q, state_d;
    logic [NN-1:0] own_q, own_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [NN-1:0] cand;
    logic          found;
    int            idx;
    // granted or multi-hot inputs never compete, so no input can win two outputs
    always_comb begin
      for (int i = 0; i < NN; i++) cand[i] = req[i][j] & ~gnt[i] & ~multi[i];
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        own_q   <= '0;
        ptr_q   <= '0;
      end else begin
        state_q <= state_d;
        own_q   <= own_d;
        ptr_q   <= ptr_d;
      end
    end
    // a released output skips arbitration on the release edge, forcing one idle cycle
    always_comb begin
      state_d = state_q;
      own_d   = own_q;
      ptr_d   = ptr_q;
      found   = 1'b0;
      idx     = 0;
      if (state_q == BUSY) begin
        if (|(tail & own_q)) begin
          state_d = IDLE;
          own_d   = '0;
        end
      end else begin
        for (int k = 0; k < NN; k++) begin
          idx = int'(ptr_q) + k;
          if (idx >= NN) idx -= NN;
          if (!found && cand[idx]) begin
            found      = 1'b1;
            state_d    = BUSY;
            own_d      = '0;
            own_d[idx] = 1'b1;
            ptr_d      = PW'(idx == NN - 1 ? 0 : idx + 1);
          end
        end
      end
    end
    assign cfg[j] = state_q == BUSY ? own_q : '0;
  end
endmodule

// File: tb/tb_rcb_alloc.sv
// tb_rcb_alloc: directed scenario bench for rcb_alloc with hand-computed expectations
module tb_rcb_alloc;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0][4:0]  req = '0;
  logic [4:0]       tail = '0;
  logic [4:0][4:0]  cfg;
  logic [4:0]       gnt;
  logic [4:0]       err;
  logic [4:0][4:0]  ec;
  int n_pass = 0;
  int n_tot = 0;
  rcb_alloc #(.NN(5), .MN(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .tail(tail), .cfg(cfg), .gnt(gnt), .err(err)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #2;
    n_tot++; if (cfg !== '0) $display("FAIL reset_cfg: got %h want 0", cfg); else n_pass++;
    n_tot++; if (gnt !== '0) $display("FAIL reset_gnt: got %b want 0", gnt); else n_pass++;
    n_tot++; if (err !== '0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_tot++; if (cfg !== '0) $display("FAIL reset_idle_cfg: got %h want 0", cfg); else n_pass++;
  endtask
  task automatic test_single;
    req[2] = 5'b00010;
    step();
    ec = '0; ec[1] = 5'b00100;
    n_tot++; if (cfg !== ec) $display("FAIL single_cfg: got %h want %h", cfg, ec); else n_pass++;
    n_tot++; if (gnt !== 5'b00100) $display("FAIL single_gnt: got %b want 00100", gnt); else n_pass++;
    n_tot++; if (dut.g_out[1].ptr_q !== 3'd3) $display("FAIL single_ptr: got %0d want 3", dut.g_out[1].ptr_q); else n_pass++;
    tail = 5'b00100; req = '0;
    step();
    tail = '0;
    n_tot++; if (cfg !== '0) $display("FAIL single_rel_cfg: got %h want 0", cfg); else n_pass++;
    n_tot++; if (gnt !== '0) $display("FAIL single_rel_gnt: got %b want 0", gnt); else n_pass++;
  endtask
  task automatic test_round_robin;
    req[0] = 5'b00001; req[3] = 5'b00001; req[4] = 5'b00001;
    step();
    n_tot++; if (cfg[0] !== 5'b00001) $display("FAIL rr_g0: got %b want 00001", cfg[0]); else n_pass++;
    n_tot++; if (dut.g_out[0].ptr_q !== 3'd1) $display("FAIL rr_ptr1: got %0d want 1", dut.g_out[0].ptr_q); else n_pass++;
    tail = 5'b00001;
    step();
    tail = '0;
    n_tot++; if (cfg[0] !== 5'b00000) $display("FAIL rr_idle1: got %b want 00000", cfg[0]); else n_pass++;
    step();
    n_tot++; if (cfg[0] !== 5'b01000) $display("FAIL rr_g3: got %b want 01000", cfg[0]); else n_pass++;
    n_tot++; if (dut.g_out[0].ptr_q !== 3'd4) $display("FAIL rr_ptr4: got %0d want 4", dut.g_out[0].ptr_q); else n_pass++;
    tail = 5'b01000;
    step();
    tail = '0;
    n_tot++; if (cfg[0] !== 5'b00000) $display("FAIL rr_idle2: got %b want 00000", cfg[0]); else n_pass++;
    step();
    n_tot++; if (cfg[0] !== 5'b10000) $display("FAIL rr_g4: got %b want 10000", cfg[0]); else n_pass++;
    n_tot++; if (dut.g_out[0].ptr_q !== 3'd0) $display("FAIL rr_wrap: got %0d want 0", dut.g_out[0].ptr_q); else n_pass++;
    tail = 5'b10000;
    step();
    tail = '0;
    n_tot++; if (cfg[0] !== 5'b00000) $display("FAIL rr_idle3: got %b want 00000", cfg[0]); else n_pass++;
    step();
    n_tot++; if (cfg[0] !== 5'b00001) $display("FAIL rr_g0b: got %b want 00001", cfg[0]); else n_pass++;
    req = '0; tail = 5'b00001;
    step();
    tail = '0;
    n_tot++; if (gnt !== '0) $display("FAIL rr_done_gnt: got %b want 0", gnt); else n_pass++;
  endtask
  task automatic test_parallel;
    req[0] = 5'b00100; req[1] = 5'b00100; req[4] = 5'b00001;
    step();
    ec = '0; ec[2] = 5'b00001; ec[0] = 5'b10000;
    n_tot++; if (cfg !== ec) $display("FAIL par_cfg: got %h want %h", cfg, ec); else n_pass++;
    n_tot++; if (gnt !== 5'b10001) $display("FAIL par_gnt: got %b want 10001", gnt); else n_pass++;
    tail = 5'b10000; req[4] = '0;
    step();
    tail = '0;
    ec = '0; ec[2] = 5'b00001;
    n_tot++; if (cfg !== ec) $display("FAIL par_tail4_cfg: got %h want %h", cfg, ec); else n_pass++;
    n_tot++; if (gnt !== 5'b00001) $display("FAIL par_tail4_gnt: got %b want 00001", gnt); else n_pass++;
  endtask
  task automatic test_hold;
    req[0] = '0; tail = 5'b01010;
    step();
    tail = '0;
    ec = '0; ec[2] = 5'b00001;
    n_tot++; if (cfg !== ec) $display("FAIL hold_cfg: got %h want %h", cfg, ec); else n_pass++;
    tail = 5'b00001;
    step();
    tail = '0;
    n_tot++; if (cfg !== '0) $display("FAIL hold_release: got %h want 0", cfg); else n_pass++;
    step();
    ec = '0; ec[2] = 5'b00010;
    n_tot++; if (cfg !== ec) $display("FAIL hold_regrant: got %h want %h", cfg, ec); else n_pass++;
    n_tot++; if (dut.g_out[2].ptr_q !== 3'd2) $display("FAIL hold_ptr: got %0d want 2", dut.g_out[2].ptr_q); else n_pass++;
    req = '0; tail = 5'b00010;
    step();
    tail = '0;
  endtask
  task automatic test_err;
    req[3] = 5'b00110;
    step();
    n_tot++; if (err !== 5'b01000) $display("FAIL err_pulse: got %b want 01000", err); else n_pass++;
    n_tot++; if (cfg !== '0) $display("FAIL err_nogrant: got %h want 0", cfg); else n_pass++;
    step();
    n_tot++; if (err !== 5'b01000) $display("FAIL err_repeat: got %b want 01000", err); else n_pass++;
    req[3] = 5'b00100;
    step();
    ec = '0; ec[2] = 5'b01000;
    n_tot++; if (err !== '0) $display("FAIL err_clear: got %b want 0", err); else n_pass++;
    n_tot++; if (cfg !== ec) $display("FAIL err_fixed_cfg: got %h want %h", cfg, ec); else n_pass++;
    n_tot++; if (gnt !== 5'b01000) $display("FAIL err_fixed_gnt: got %b want 01000", gnt); else n_pass++;
    req = '0; tail = 5'b01000;
    step();
    tail = '0;
  endtask
  task automatic test_async_reset;
    req[0] = 5'b00001; req[1] = 5'b00010; req[2] = 5'b01000; req[4] = 5'b00011;
    step();
    ec = '0; ec[0] = 5'b00001; ec[1] = 5'b00010; ec[3] = 5'b00100;
    n_tot++; if (cfg !== ec) $display("FAIL ar_setup_cfg: got %h want %h", cfg, ec); else n_pass++;
    n_tot++; if (err !== 5'b10000) $display("FAIL ar_setup_err: got %b want 10000", err); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_tot++; if (cfg !== '0) $display("FAIL ar_cfg: got %h want 0", cfg); else n_pass++;
    n_tot++; if (gnt !== '0) $display("FAIL ar_gnt: got %b want 0", gnt); else n_pass++;
    n_tot++; if (err !== '0) $display("FAIL ar_err: got %b want 0", err); else n_pass++;
    req = '0;
    step();
    @(negedge clk);
    rst_n = 1'b1;
    req[0] = 5'b00001; req[3] = 5'b00001;
    step();
    n_tot++; if (cfg[0] !== 5'b00001) $display("FAIL ar_restart: got %b want 00001", cfg[0]); else n_pass++;
    n_tot++; if (dut.g_out[0].ptr_q !== 3'd1) $display("FAIL ar_ptr: got %0d want 1", dut.g_out[0].ptr_q); else n_pass++;
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_parallel();
    test_hold();
    test_err();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
